// File: rtl/writeback_stage_buffer.sv
// MEM->WB payload buffer with valid/ready handshake, optional 2-entry skid,
// synchronous flush and a saturating downstream-stall counter.
module writeback_stage_buffer #(
    parameter int DATA_WIDTH      = 32,
    parameter int REGISTER_WIDTH  = 5,
    parameter int SKID_ENABLE     = 1,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_m_i,
    output logic                       ready_m_o,
    input  logic [DATA_WIDTH-1:0]      alu_result_m_i,
    input  logic [DATA_WIDTH-1:0]      pc_plus4_m_i,
    input  logic [DATA_WIDTH-1:0]      read_data_m_i,
    input  logic [DATA_WIDTH-1:0]      imm_ext_m_i,
    input  logic [REGISTER_WIDTH-1:0]  rd_m_i,
    input  logic [1:0]                 result_src_m_i,
    input  logic                       reg_write_m_i,
    input  logic                       flush_i,
    output logic                       valid_w_o,
    input  logic                       ready_w_i,
    output logic [DATA_WIDTH-1:0]      alu_result_w_o,
    output logic [DATA_WIDTH-1:0]      pc_plus4_w_o,
    output logic [DATA_WIDTH-1:0]      read_data_w_o,
    output logic [DATA_WIDTH-1:0]      imm_ext_w_o,
    output logic [REGISTER_WIDTH-1:0]  rd_w_o,
    output logic [1:0]                 result_src_w_o,
    output logic                       reg_write_w_o,
    output logic [STALL_CNT_WIDTH-1:0] stall_count_o
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     alu_result;
        logic [DATA_WIDTH-1:0]     pc_plus4;
        logic [DATA_WIDTH-1:0]     read_data;
        logic [DATA_WIDTH-1:0]     imm_ext;
        logic [REGISTER_WIDTH-1:0] rd;
        logic [1:0]                result_src;
        logic                      reg_write;
    } wb_entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t                     state_q, state_d;
    wb_entry_t                  main_q, skid_q, in_e;
    logic                       ready_q;
    logic                       accept, consume;
    logic                       load_in, load_skid, load_fwd;
    logic [STALL_CNT_WIDTH-1:0] stall_q;

    assign in_e = '{alu_result: alu_result_m_i, pc_plus4: pc_plus4_m_i,
                    read_data: read_data_m_i, imm_ext: imm_ext_m_i, rd: rd_m_i,
                    result_src: result_src_m_i, reg_write: reg_write_m_i};

    assign valid_w_o = (state_q != EMPTY);
    assign consume   = valid_w_o & ready_w_i;
    assign accept    = valid_m_i & ready_m_o;

    // ready_q doubles as an out-of-reset flag so ready stays low during reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (SKID_ENABLE != 0) ? (state_d != TWO) : 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_in   = 1'b0;
        load_skid = 1'b0;
        load_fwd  = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d = ONE;
                    load_in = 1'b1;
                end
                ONE: begin
                    if (accept && consume) begin
                        load_in = 1'b1;
                    end else if (accept) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (consume) begin
                    state_d  = ONE;
                    load_fwd = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        if (SKID_ENABLE != 0)
            ready_m_o = ready_q;
        else
            ready_m_o = ready_q & (ready_w_i | ~valid_w_o);
        reg_write_w_o = main_q.reg_write & valid_w_o;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_in)
                main_q <= in_e;
            else if (load_fwd)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= in_e;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (valid_w_o && !ready_w_i && !(&stall_q))
            stall_q <= stall_q + 1'b1;
    end

    assign alu_result_w_o = main_q.alu_result;
    assign pc_plus4_w_o   = main_q.pc_plus4;
    assign read_data_w_o  = main_q.read_data;
    assign imm_ext_w_o    = main_q.imm_ext;
    assign rd_w_o         = main_q.rd;
    assign result_src_w_o = main_q.result_src;
    assign stall_count_o  = stall_q;

endmodule

// File: tb/tb_writeback_stage_buffer.sv
// Drives a skid and a non-skid buffer from shared inputs; each is compared
// every cycle against a capacity-limited FIFO model.
module tb_writeback_stage_buffer;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] rdat;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [1:0]  src;
        logic        rw;
    } ent_t;

    logic clk, rst, valid_m, ready_w, flush;
    ent_t in_e;

    logic        r1, v1, rw1, r0, v0, rw0;
    logic [31:0] a1, p1, d1, i1, a0, p0, d0, i0;
    logic [4:0]  rd1, rd0;
    logic [1:0]  s1, s0;
    logic [3:0]  c1, c0;

    writeback_stage_buffer #(.DATA_WIDTH(32), .REGISTER_WIDTH(5), .SKID_ENABLE(1), .STALL_CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .valid_m_i(valid_m), .ready_m_o(r1),
        .alu_result_m_i(in_e.alu), .pc_plus4_m_i(in_e.pc), .read_data_m_i(in_e.rdat), .imm_ext_m_i(in_e.imm),
        .rd_m_i(in_e.rd), .result_src_m_i(in_e.src), .reg_write_m_i(in_e.rw), .flush_i(flush),
        .valid_w_o(v1), .ready_w_i(ready_w), .alu_result_w_o(a1), .pc_plus4_w_o(p1), .read_data_w_o(d1),
        .imm_ext_w_o(i1), .rd_w_o(rd1), .result_src_w_o(s1), .reg_write_w_o(rw1), .stall_count_o(c1));

    writeback_stage_buffer #(.DATA_WIDTH(32), .REGISTER_WIDTH(5), .SKID_ENABLE(0), .STALL_CNT_WIDTH(4)) dut0 (
        .clk(clk), .rst(rst), .valid_m_i(valid_m), .ready_m_o(r0),
        .alu_result_m_i(in_e.alu), .pc_plus4_m_i(in_e.pc), .read_data_m_i(in_e.rdat), .imm_ext_m_i(in_e.imm),
        .rd_m_i(in_e.rd), .result_src_m_i(in_e.src), .reg_write_m_i(in_e.rw), .flush_i(flush),
        .valid_w_o(v0), .ready_w_i(ready_w), .alu_result_w_o(a0), .pc_plus4_w_o(p0), .read_data_w_o(d0),
        .imm_ext_w_o(i0), .rd_w_o(rd0), .result_src_w_o(s0), .reg_write_w_o(rw0), .stall_count_o(c0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: q1 holds up to two entries, q0 up to one
    ent_t q1[$];
    ent_t q0[$];
    ent_t last1, last0;
    int   cnt1, cnt0;
    bit   oor;

    function automatic bit mready(input bit skid);
        if (!oor) return 1'b0;
        if (skid) return q1.size() < 2;
        return (q0.size() == 0) || ready_w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string nm, input bit skid, input logic v, input logic r,
                             input logic [31:0] a, input logic [31:0] p, input logic [31:0] d,
                             input logic [31:0] i, input logic [4:0] rd, input logic [1:0] s,
                             input logic rw, input logic [3:0] c);
        int   qs;
        ent_t h;
        int   ec;
        qs = skid ? q1.size() : q0.size();
        h  = skid ? ((qs > 0) ? q1[0] : last1) : ((qs > 0) ? q0[0] : last0);
        ec = skid ? cnt1 : cnt0;
        chk({nm, ".valid"}, {31'd0, v}, {31'd0, qs > 0});
        chk({nm, ".ready"}, {31'd0, r}, {31'd0, mready(skid)});
        chk({nm, ".alu"}, a, h.alu);
        chk({nm, ".pc4"}, p, h.pc);
        chk({nm, ".rdata"}, d, h.rdat);
        chk({nm, ".imm"}, i, h.imm);
        chk({nm, ".rd"}, {27'd0, rd}, {27'd0, h.rd});
        chk({nm, ".src"}, {30'd0, s}, {30'd0, h.src});
        chk({nm, ".regwr"}, {31'd0, rw}, {31'd0, (qs > 0) && h.rw});
        chk({nm, ".stall"}, {28'd0, c}, ec);
    endtask

    task automatic check_both();
        check_dut("skid", 1'b1, v1, r1, a1, p1, d1, i1, rd1, s1, rw1, c1);
        check_dut("noskid", 1'b0, v0, r0, a0, p0, d0, i0, rd0, s0, rw0, c0);
    endtask

    task automatic model_reset();
        q1.delete();
        q0.delete();
        last1 = '0;
        last0 = '0;
        cnt1  = 0;
        cnt0  = 0;
        oor   = 1'b0;
    endtask

    // inputs already driven; check, then advance one edge and update the model
    task automatic step();
        bit acc1, acc0, con1, con0;
        #1;
        check_both();
        acc1 = valid_m && mready(1'b1);
        acc0 = valid_m && mready(1'b0);
        con1 = (q1.size() > 0) && ready_w;
        con0 = (q0.size() > 0) && ready_w;
        if (q1.size() > 0 && !ready_w && cnt1 < 15) cnt1++;
        if (q0.size() > 0 && !ready_w && cnt0 < 15) cnt0++;
        @(posedge clk);
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (con1) void'(q1.pop_front());
            if (con0) void'(q0.pop_front());
            if (acc1) q1.push_back(in_e);
            if (acc0) q0.push_back(in_e);
        end
        if (q1.size() > 0) last1 = q1[0];
        if (q0.size() > 0) last0 = q0[0];
        oor = 1'b1;
        #1;
    endtask

    task automatic drv(input bit v, input logic [31:0] alu, input bit rw, input logic [4:0] rd,
                       input bit rdy, input bit fl);
        in_e.alu  = alu;
        in_e.pc   = $urandom;
        in_e.rdat = $urandom;
        in_e.imm  = $urandom;
        in_e.rd   = rd;
        in_e.src  = 2'($urandom);
        in_e.rw   = rw;
        valid_m   = v;
        ready_w   = rdy;
        flush     = fl;
        step();
    endtask

    initial begin
        rst = 1'b1; valid_m = 1'b0; ready_w = 1'b0; flush = 1'b0; in_e = '0;
        model_reset();
        #2;
        check_both();
        #1 rst = 1'b0;

        // first cycle after reset: ready still low
        drv(0, 32'h0, 0, 5'd0, 1, 0);

        // streaming
        drv(1, 32'h10, 1, 5'd1, 1, 0);
        drv(1, 32'h20, 1, 5'd2, 1, 0);
        drv(1, 32'h30, 0, 5'd3, 1, 0);
        drv(0, 32'h0, 0, 5'd0, 1, 0);
        drv(0, 32'h0, 0, 5'd0, 1, 0);

        // back-pressure then release
        drv(1, 32'hA, 1, 5'd4, 0, 0);
        drv(1, 32'hB, 1, 5'd6, 0, 0);
        drv(0, 32'h0, 0, 5'd0, 0, 0);
        drv(0, 32'h0, 0, 5'd0, 1, 0);
        drv(0, 32'h0, 0, 5'd0, 1, 0);
        drv(0, 32'h0, 0, 5'd0, 1, 0);

        // flush while full, with a same-cycle offer of 0xC
        drv(1, 32'h1A, 1, 5'd7, 0, 0);
        drv(1, 32'h1B, 1, 5'd8, 0, 0);
        drv(1, 32'hC, 1, 5'd9, 0, 1);
        drv(0, 32'h0, 0, 5'd0, 1, 0);

        // reg_write qualification
        drv(1, 32'h77, 1, 5'd5, 1, 0);
        drv(0, 32'h0, 0, 5'd0, 1, 0);
        drv(0, 32'h0, 0, 5'd0, 1, 0);
        chk("rw_idle_rd", {27'd0, rd1}, 32'd5);
        chk("rw_idle_regwr", {31'd0, rw1}, 32'd0);

        // counter saturation
        drv(1, 32'h99, 1, 5'd10, 0, 0);
        for (int k = 0; k < 20; k++) drv(0, 32'h0, 0, 5'd0, 0, 0);
        chk("stall_sat", {28'd0, c1}, 32'd15);

        // fill, then async reset between edges
        drv(1, 32'h2A, 1, 5'd11, 0, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_both();
        #1 rst = 1'b0;
        drv(0, 32'h0, 0, 5'd0, 1, 0);
        drv(1, 32'h55, 1, 5'd12, 1, 0);
        drv(0, 32'h0, 0, 5'd0, 1, 0);

        // non-skid combinational ready: hold one entry, then release
        drv(1, 32'h66, 0, 5'd13, 0, 0);
        drv(0, 32'h0, 0, 5'd0, 0, 0);
        drv(0, 32'h0, 0, 5'd0, 1, 0);

        // random traffic
        for (int k = 0; k < 400; k++)
            drv($urandom_range(99, 0) < 70, $urandom, 1'($urandom), 5'($urandom),
                $urandom_range(99, 0) < 60, $urandom_range(99, 0) < 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
